// File: rtl/regfile_sb.sv
// regfile_sb: register file with hardwired-zero r0, two async read ports, one sync write port and a busy scoreboard.
// Ports: clk, rst (sync, active-high); raddr1/raddr2 -> rdata1/rdata2, rbusy1/rbusy2 (combinational);
// we/waddr/wdata writeback port; mark_en/mark_addr sets a busy bit; busy_vec is the registered scoreboard.
// Optional macro REGFILE_SB_BYPASS_EN forwards same-cycle writeback data and busy clearing to the read ports.
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  localparam int AW = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  output logic            rbusy1,
  output logic            rbusy2,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic            mark_en,
  input  logic [AW-1:0]   mark_addr,
  output logic [NREGS-1:0] busy_vec
);
  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy;
  logic wv, mv, hit1, hit2, remark;
  assign wv = we && waddr != '0;
  assign mv = mark_en && mark_addr != '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (wv) begin
        regs[waddr] <= wdata;
        busy[waddr] <= 1'b0;
      end
      // issued after the write so a same-address mark leaves the register busy
      if (mv) busy[mark_addr] <= 1'b1;
    end
  end
  assign busy_vec = busy;
  assign remark = mv && mark_addr == waddr;
`ifdef REGFILE_SB_BYPASS_EN
  assign hit1 = wv && waddr == raddr1;
  assign hit2 = wv && waddr == raddr2;
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif
  always_comb begin
    rdata1 = hit1 ? wdata : raddr1 == '0 ? '0 : regs[raddr1];
    rdata2 = hit2 ? wdata : raddr2 == '0 ? '0 : regs[raddr2];
    rbusy1 = hit1 ? remark : busy[raddr1];
    rbusy2 = hit2 ? remark : busy[raddr2];
  end
endmodule
